// File: rtl/code_lock.sv
// Digit-entry code lock with lockout after repeated failures and in-place
// reprogramming while open. The first digit entered sits in the LSBs of the code.
module code_lock #(
  parameter int unsigned                  DIGIT_W      = 4,
  parameter int unsigned                  CODE_LEN     = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0]  DEFAULT_CODE = {4'd1, 4'd0, 4'd1, 4'd1},
  parameter int unsigned                  MAX_FAIL     = 3,
  parameter int unsigned                  OPEN_CYC     = 8,
  parameter int unsigned                  LOCKOUT_CYC  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            digit_valid,
  input  logic [DIGIT_W-1:0]              digit,
  input  logic                            clear,
  input  logic                            prog_req,
  output logic                            unlock,
  output logic                            alarm,
  output logic                            prog_mode,
  output logic [$clog2(CODE_LEN+1)-1:0]   entry_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int unsigned CW   = $clog2(CODE_LEN + 1);
  localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned KW   = DIGIT_W * CODE_LEN;

  typedef enum logic [1:0] {StEntry, StOpen, StLockout, StProg} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   code_q, code_d;
  // Digit buffer: holds the attempt in ENTRY and acts as the shadow code in PROG.
  logic [KW-1:0]   buf_q, buf_d;
  logic [KW-1:0]   cand;
  logic [CW-1:0]   entry_cnt_q, entry_cnt_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            unlock_q, alarm_q, prog_mode_q;
  logic            last_digit;

  // Candidate word: buffered digits with the incoming digit dropped into its slot.
  always_comb begin
    cand = buf_q;
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      if (entry_cnt_q == CW'(i)) cand[i*DIGIT_W +: DIGIT_W] = digit;
    end
  end

  assign last_digit = (entry_cnt_q == CW'(CODE_LEN - 1));

  // Next-state logic for the FSM, counters, timer and code register.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    buf_d       = buf_q;
    entry_cnt_d = entry_cnt_q;
    fail_d      = fail_q;
    timer_d     = timer_q;
    case (state_q)
      StEntry: begin
        if (clear) begin
          entry_cnt_d = '0;
        end else if (digit_valid) begin
          if (last_digit) begin
            entry_cnt_d = '0;
            if (cand == code_q) begin
              state_d = StOpen;
              fail_d  = '0;
              timer_d = TW'(OPEN_CYC - 1);
            end else if (fail_q == FW'(MAX_FAIL - 1)) begin
              state_d = StLockout;
              fail_d  = FW'(MAX_FAIL);
              timer_d = TW'(LOCKOUT_CYC - 1);
            end else begin
              fail_d = fail_q + FW'(1);
            end
          end else begin
            buf_d       = cand;
            entry_cnt_d = entry_cnt_q + CW'(1);
          end
        end
      end
      StOpen: begin
        // prog_req is checked ahead of expiry so the final open cycle still honours it.
        if (prog_req) begin
          state_d = StProg;
        end else if (timer_q == '0) begin
          state_d = StEntry;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StLockout: begin
        if (timer_q == '0) begin
          state_d = StEntry;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StProg: begin
        if (clear) begin
          state_d     = StEntry;
          entry_cnt_d = '0;
        end else if (digit_valid) begin
          if (last_digit) begin
            code_d      = cand;
            state_d     = StEntry;
            entry_cnt_d = '0;
          end else begin
            buf_d       = cand;
            entry_cnt_d = entry_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = StEntry;
    endcase
  end

  // State registers with synchronous active-low reset; outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StEntry;
      code_q      <= DEFAULT_CODE;
      buf_q       <= '0;
      entry_cnt_q <= '0;
      fail_q      <= '0;
      timer_q     <= '0;
      unlock_q    <= 1'b0;
      alarm_q     <= 1'b0;
      prog_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      buf_q       <= buf_d;
      entry_cnt_q <= entry_cnt_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
      unlock_q    <= (state_d == StOpen);
      alarm_q     <= (state_d == StLockout);
      prog_mode_q <= (state_d == StProg);
    end
  end

  assign unlock    = unlock_q;
  assign alarm     = alarm_q;
  assign prog_mode = prog_mode_q;
  assign entry_cnt = entry_cnt_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_code_lock.sv
// Directed self-checking bench for code_lock with default parameters.
module tb_code_lock;

  logic       clk;
  logic       rst;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic       prog_req;
  logic       unlock;
  logic       alarm;
  logic       prog_mode;
  logic [2:0] entry_cnt;
  logic [1:0] fail_cnt;

  int n_cmp = 0;
  int n_err = 0;

  code_lock dut (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (digit_valid),
    .digit       (digit),
    .clear       (clear),
    .prog_req    (prog_req),
    .unlock      (unlock),
    .alarm       (alarm),
    .prog_mode   (prog_mode),
    .entry_cnt   (entry_cnt),
    .fail_cnt    (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; after each call the rising edge has
  // consumed them and outputs can be sampled.
  task automatic drive(input logic v, input logic [3:0] d, input logic c, input logic p);
    digit_valid = v;
    digit       = d;
    clear       = c;
    prog_req    = p;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    drive(1'b1, a, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0);
    drive(1'b1, c, 1'b0, 1'b0);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  // Waits out an open window so later tests start in ENTRY.
  task automatic wait_closed();
    int k;
    k = 0;
    while ((unlock === 1'b1) && (k < 40)) begin
      k++;
      idle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    idle();
    n_cmp++;
    if ({unlock, alarm, prog_mode, entry_cnt, fail_cnt} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {unlock, alarm, prog_mode, entry_cnt, fail_cnt});
    end
    rst = 1'b1;
    idle();
  endtask

  task automatic test_unlock();
    int cnt;
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    n_cmp++;
    if (entry_cnt !== 3'd2) begin
      n_err++;
      $display("FAIL unlock_entry_cnt2: got %0d want 2", entry_cnt);
    end
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    n_cmp++;
    if (unlock !== 1'b1 || fail_cnt !== 2'd0 || entry_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL unlock_first_cycle: got u=%b f=%0d e=%0d want u=1 f=0 e=0",
               unlock, fail_cnt, entry_cnt);
    end
    cnt = 0;
    while ((unlock === 1'b1) && (cnt < 40)) begin
      cnt++;
      idle();
    end
    n_cmp++;
    if (cnt != 8) begin
      n_err++;
      $display("FAIL unlock_duration: got %0d want 8", cnt);
    end
  endtask

  task automatic test_lockout();
    int cnt;
    logic bad;
    logic [3:0] seq [4];
    seq[0] = 4'd1; seq[1] = 4'd1; seq[2] = 4'd0; seq[3] = 4'd1;
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    n_cmp++;
    if (entry_cnt !== 3'd3) begin
      n_err++;
      $display("FAIL no_early_abort: got entry_cnt=%0d want 3", entry_cnt);
    end
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    n_cmp++;
    if (fail_cnt !== 2'd1 || unlock !== 1'b0) begin
      n_err++;
      $display("FAIL lockout_fail1: got f=%0d u=%b want f=1 u=0", fail_cnt, unlock);
    end
    enter4(4'd1, 4'd1, 4'd1, 4'd1);
    n_cmp++;
    if (fail_cnt !== 2'd2 || alarm !== 1'b0) begin
      n_err++;
      $display("FAIL lockout_fail2: got f=%0d a=%b want f=2 a=0", fail_cnt, alarm);
    end
    enter4(4'd1, 4'd1, 4'd1, 4'd1);
    n_cmp++;
    if (alarm !== 1'b1 || fail_cnt !== 2'd3) begin
      n_err++;
      $display("FAIL lockout_enter: got a=%b f=%0d want a=1 f=3", alarm, fail_cnt);
    end
    cnt = 0;
    bad = 1'b0;
    while ((alarm === 1'b1) && (cnt < 40)) begin
      if (unlock !== 1'b0 || entry_cnt !== 3'd0) bad = 1'b1;
      cnt++;
      if (cnt <= 4) drive(1'b1, seq[cnt-1], 1'b0, 1'b0);
      else idle();
    end
    n_cmp++;
    if (cnt != 16) begin
      n_err++;
      $display("FAIL lockout_duration: got %0d want 16", cnt);
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL lockout_ignores_digits: got disturbed=%b want 0", bad);
    end
    n_cmp++;
    if (fail_cnt !== 2'd0 || entry_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL lockout_exit: got f=%0d e=%0d want f=0 e=0", fail_cnt, entry_cnt);
    end
    enter4(4'd1, 4'd1, 4'd0, 4'd1);
    n_cmp++;
    if (unlock !== 1'b1) begin
      n_err++;
      $display("FAIL lockout_then_unlock: got %b want 1", unlock);
    end
    wait_closed();
  endtask

  task automatic test_clear();
    int cnt;
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    n_cmp++;
    if (entry_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL clear_zeroes_cnt: got %0d want 0", entry_cnt);
    end
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    n_cmp++;
    if (unlock !== 1'b0 || entry_cnt !== 3'd2 || fail_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL clear_partial: got u=%b e=%0d f=%0d want u=0 e=2 f=0",
               unlock, entry_cnt, fail_cnt);
    end
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    enter4(4'd1, 4'd1, 4'd0, 4'd1);
    n_cmp++;
    if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL clear_then_unlock: got u=%b f=%0d want u=1 f=0", unlock, fail_cnt);
    end
    cnt = 0;
    while ((unlock === 1'b1) && (cnt < 40)) begin
      cnt++;
      idle();
    end
    n_cmp++;
    if (cnt != 8) begin
      n_err++;
      $display("FAIL clear_unlock_duration: got %0d want 8", cnt);
    end
  endtask

  task automatic test_prog();
    enter4(4'd1, 4'd1, 4'd0, 4'd1);
    idle();
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if (prog_mode !== 1'b1 || unlock !== 1'b0) begin
      n_err++;
      $display("FAIL prog_enter: got p=%b u=%b want p=1 u=0", prog_mode, unlock);
    end
    drive(1'b1, 4'd7, 1'b0, 1'b0);
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    n_cmp++;
    if (entry_cnt !== 3'd2 || prog_mode !== 1'b1) begin
      n_err++;
      $display("FAIL prog_midway: got e=%0d p=%b want e=2 p=1", entry_cnt, prog_mode);
    end
    drive(1'b1, 4'd9, 1'b0, 1'b0);
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    n_cmp++;
    if (prog_mode !== 1'b0 || unlock !== 1'b0 || entry_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL prog_done: got p=%b u=%b e=%0d want p=0 u=0 e=0",
               prog_mode, unlock, entry_cnt);
    end
    enter4(4'd1, 4'd1, 4'd0, 4'd1);
    n_cmp++;
    if (unlock !== 1'b0 || fail_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL prog_old_code: got u=%b f=%0d want u=0 f=1", unlock, fail_cnt);
    end
    enter4(4'd7, 4'd3, 4'd9, 4'd2);
    n_cmp++;
    if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL prog_new_code: got u=%b f=%0d want u=1 f=0", unlock, fail_cnt);
    end
    // Sit in the open window until its eighth and final cycle, then request programming.
    for (int i = 0; i < 7; i++) idle();
    n_cmp++;
    if (unlock !== 1'b1) begin
      n_err++;
      $display("FAIL open_last_cycle: got %b want 1", unlock);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if (prog_mode !== 1'b1) begin
      n_err++;
      $display("FAIL prog_on_last_cycle: got %b want 1", prog_mode);
    end
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    n_cmp++;
    if (prog_mode !== 1'b0 || entry_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL prog_abort: got p=%b e=%0d want p=0 e=0", prog_mode, entry_cnt);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if (prog_mode !== 1'b0) begin
      n_err++;
      $display("FAIL prog_req_in_entry: got %b want 0", prog_mode);
    end
    enter4(4'd7, 4'd3, 4'd9, 4'd2);
    n_cmp++;
    if (unlock !== 1'b1) begin
      n_err++;
      $display("FAIL prog_abort_keeps_code: got %b want 1", unlock);
    end
    wait_closed();
  endtask

  task automatic test_reset_in_prog();
    enter4(4'd7, 4'd3, 4'd9, 4'd2);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    drive(1'b1, 4'd6, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 4'd4, 1'b1, 1'b1);
    n_cmp++;
    if ({unlock, alarm, prog_mode, entry_cnt, fail_cnt} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_in_prog: got %b want 00000000",
               {unlock, alarm, prog_mode, entry_cnt, fail_cnt});
    end
    rst = 1'b1;
    enter4(4'd1, 4'd1, 4'd0, 4'd1);
    n_cmp++;
    if (unlock !== 1'b1) begin
      n_err++;
      $display("FAIL reset_restores_code: got %b want 1", unlock);
    end
    wait_closed();
  endtask

  task automatic test_clear_collision();
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 1'b1, 1'b0);
    n_cmp++;
    if (unlock !== 1'b0 || entry_cnt !== 3'd0 || fail_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL clear_wins: got u=%b e=%0d f=%0d want u=0 e=0 f=0",
               unlock, entry_cnt, fail_cnt);
    end
  endtask

  initial begin
    rst         = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
    clear       = 1'b0;
    prog_req    = 1'b0;
    @(negedge clk);
    test_reset();
    test_unlock();
    test_lockout();
    test_clear();
    test_prog();
    test_reset_in_prog();
    test_clear_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
